// File: rtl/vdp_bg_fetch.sv
// rtl/vdp_bg_fetch.sv - VDP background tile fetcher (Mode 4 name table + bitplanes)
// Three 8-slot VRAM bursts per group of four tiles, then a valid/ready tile-row stream.
module vdp_bg_fetch #(
  parameter int BURST_CYCLES = 8,
  parameter int NUM_TILES    = 32
) (
  input  logic             clk_100,
  input  logic             rst_L,
  input  logic             line_start,
  input  logic [7:0]       line,
  input  logic [7:0]       v_scroll,
  input  logic [3:0]       nt_base,
  output logic [7:0][13:0] vga_addr,
  output logic             VRAM_go,
  input  logic [7:0][7:0]  vga_data_out,
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [3:0][7:0]  tile_planes,
  output logic             tile_pal,
  output logic             tile_prio,
  output logic [4:0]       tile_col,
  output logic             busy,
  output logic             line_done
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_NT_GO   = 4'd1;
  localparam logic [3:0] S_NT_WAIT = 4'd2;
  localparam logic [3:0] S_PA_GO   = 4'd3;
  localparam logic [3:0] S_PA_WAIT = 4'd4;
  localparam logic [3:0] S_PB_GO   = 4'd5;
  localparam logic [3:0] S_PB_WAIT = 4'd6;
  localparam logic [3:0] S_EMIT    = 4'd7;
  localparam logic [3:0] S_DONE    = 4'd8;

  localparam int CW = (BURST_CYCLES > 1) ? $clog2(BURST_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(BURST_CYCLES - 1);
  localparam logic [2:0]    LAST_GROUP = 3'(NUM_TILES / 4 - 1);

  logic [3:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_group;
  logic [1:0]             r_k;
  logic [2:0]             r_fine;
  logic [4:0]             r_trow;
  logic [2:0]             r_ntb;
  logic [3:0][7:0]        r_lo;
  logic [3:0][4:0]        r_hi;
  logic [3:0][3:0][7:0]   r_planes;
  logic [7:0][13:0]       r_addr;

  logic [8:0]             w_sum;
  logic [8:0]             w_row1;
  logic [8:0]             w_row;
  logic [3:0][2:0]        w_frow;
  logic [7:0][13:0]       w_addr;
  logic                   w_last;
  logic                   w_unused;

  // Row wraps at 224 lines; a 9-bit sum never needs more than two subtractions.
  assign w_sum  = {1'b0, line} + {1'b0, v_scroll};
  assign w_row1 = (w_sum  >= 9'd224) ? w_sum  - 9'd224 : w_sum;
  assign w_row  = (w_row1 >= 9'd224) ? w_row1 - 9'd224 : w_row1;

  assign w_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_frow = '0;
    for (int k = 0; k < 4; k++)
      w_frow[2'(k)] = r_hi[2'(k)][2] ? ~r_fine : r_fine;
  end

  // New burst addresses appear only in GO cycles and are then held by r_addr.
  always_comb begin
    w_addr = r_addr;
    for (int i = 0; i < 8; i++) begin
      if (r_state == S_NT_GO)
        w_addr[3'(i)] = {r_ntb, r_trow, r_group, 3'(i)};
      else if (r_state == S_PA_GO)
        w_addr[3'(i)] = {r_hi[2'(i / 4)][0], r_lo[2'(i / 4)], w_frow[2'(i / 4)], 2'(i % 4)};
      else if (r_state == S_PB_GO)
        w_addr[3'(i)] = {r_hi[2'(2 + i / 4)][0], r_lo[2'(2 + i / 4)], w_frow[2'(2 + i / 4)], 2'(i % 4)};
    end
  end

  function automatic logic [7:0] f_rev(input logic [7:0] b);
    logic [7:0] r;
    for (int j = 0; j < 8; j++)
      r[3'(j)] = b[3'(7 - j)];
    return r;
  endfunction

  always_ff @(posedge clk_100 or negedge rst_L) begin
    if (!rst_L) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_group  <= '0;
      r_k      <= '0;
      r_fine   <= '0;
      r_trow   <= '0;
      r_ntb    <= '0;
      r_lo     <= '0;
      r_hi     <= '0;
      r_planes <= '0;
      r_addr   <= '0;
    end else begin
      r_addr <= w_addr;
      case (r_state)
        S_IDLE: begin
          if (line_start) begin
            r_fine  <= w_row[2:0];
            r_trow  <= w_row[7:3];
            r_ntb   <= nt_base[3:1];
            r_group <= '0;
            r_k     <= '0;
            r_state <= S_NT_GO;
          end
        end
        S_NT_GO: begin
          r_cnt   <= '0;
          r_state <= S_NT_WAIT;
        end
        S_NT_WAIT: begin
          if (w_last) begin
            for (int k = 0; k < 4; k++) begin
              r_lo[2'(k)] <= vga_data_out[3'(2 * k)];
              r_hi[2'(k)] <= vga_data_out[3'(2 * k + 1)][4:0];
            end
            r_state <= S_PA_GO;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PA_GO: begin
          r_cnt   <= '0;
          r_state <= S_PA_WAIT;
        end
        S_PA_WAIT: begin
          if (w_last) begin
            for (int t = 0; t < 2; t++)
              for (int p = 0; p < 4; p++)
                r_planes[2'(t)][2'(p)] <= r_hi[2'(t)][1] ? f_rev(vga_data_out[3'(4 * t + p)])
                                                         : vga_data_out[3'(4 * t + p)];
            r_state <= S_PB_GO;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_PB_GO: begin
          r_cnt   <= '0;
          r_state <= S_PB_WAIT;
        end
        S_PB_WAIT: begin
          if (w_last) begin
            for (int t = 0; t < 2; t++)
              for (int p = 0; p < 4; p++)
                r_planes[2'(t + 2)][2'(p)] <= r_hi[2'(t + 2)][1] ? f_rev(vga_data_out[3'(4 * t + p)])
                                                                 : vga_data_out[3'(4 * t + p)];
            r_state <= S_EMIT;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_EMIT: begin
          // Leaving EMIT after the last tile gives the one-cycle valid gap.
          if (tile_ready) begin
            if (r_k == 2'd3) begin
              r_k <= '0;
              if (r_group == LAST_GROUP) begin
                r_state <= S_DONE;
              end else begin
                r_group <= r_group + 3'd1;
                r_state <= S_NT_GO;
              end
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
        end
        S_DONE: begin
          r_group <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign vga_addr    = w_addr;
  assign VRAM_go     = (r_state == S_NT_GO) || (r_state == S_PA_GO) || (r_state == S_PB_GO);
  assign busy        = (r_state != S_IDLE);
  assign line_done   = (r_state == S_DONE);
  assign tile_valid  = (r_state == S_EMIT);
  assign tile_planes = r_planes[r_k];
  assign tile_pal    = r_hi[r_k][3];
  assign tile_prio   = r_hi[r_k][4];
  assign tile_col    = {r_group, r_k};

  assign w_unused = ^{nt_base[0], w_row[8], vga_data_out[1][7:5], vga_data_out[3][7:5],
                      vga_data_out[5][7:5], vga_data_out[7][7:5]};

endmodule

// File: tb/tb_vdp_bg_fetch.sv
// tb/tb_vdp_bg_fetch.sv - self-checking bench for vdp_bg_fetch
// Latency-accurate VRAM responder plus a whole-line reference model built from the tile rules.
module tb_vdp_bg_fetch;

  logic             clk_100 = 1'b0;
  logic             rst_L = 1'b0;
  logic             line_start = 1'b0;
  logic [7:0]       line = 8'd0;
  logic [7:0]       v_scroll = 8'd0;
  logic [3:0]       nt_base = 4'hE;
  logic [7:0][13:0] vga_addr;
  logic             VRAM_go;
  logic [7:0][7:0]  vga_data_out;
  logic             tile_valid;
  logic             tile_ready = 1'b1;
  logic [3:0][7:0]  tile_planes;
  logic             tile_pal;
  logic             tile_prio;
  logic [4:0]       tile_col;
  logic             busy;
  logic             line_done;

  int total = 0;
  int bad = 0;
  int rdy_mode = 0;

  always #5 clk_100 = ~clk_100;

  vdp_bg_fetch dut (
    .clk_100(clk_100), .rst_L(rst_L), .line_start(line_start), .line(line),
    .v_scroll(v_scroll), .nt_base(nt_base), .vga_addr(vga_addr), .VRAM_go(VRAM_go),
    .vga_data_out(vga_data_out), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .tile_planes(tile_planes), .tile_pal(tile_pal), .tile_prio(tile_prio),
    .tile_col(tile_col), .busy(busy), .line_done(line_done)
  );

  // VRAM: data for the addresses seen with the go pulse is only valid 8 cycles later.
  logic [7:0]       vram [16384];
  logic [7:0][13:0] snap = '0;
  int               bcnt = 0;

  always @(posedge clk_100) begin
    if (VRAM_go) begin
      snap <= vga_addr;
      bcnt <= 1;
    end else if (bcnt != 0 && bcnt < 8) begin
      bcnt <= bcnt + 1;
    end
  end

  always_comb begin
    vga_data_out = '0;
    for (int i = 0; i < 8; i++)
      vga_data_out[3'(i)] = (bcnt == 8) ? vram[snap[3'(i)]] : (8'h5A ^ 8'(i * 37));
  end

  typedef struct packed {
    logic [3:0][7:0] planes;
    logic            pal;
    logic            prio;
    logic [4:0]      col;
  } tile_t;

  tile_t            obs[$];
  tile_t            exp_q[$];
  logic [7:0][13:0] go_addr[$];
  int               go_cnt = 0;
  int               done_cnt = 0;

  always @(negedge clk_100) begin
    tile_t t;
    if (rst_L) begin
      if (VRAM_go) begin
        go_cnt = go_cnt + 1;
        go_addr.push_back(vga_addr);
      end
      if (line_done) done_cnt = done_cnt + 1;
      if (tile_valid && tile_ready) begin
        t.planes = tile_planes;
        t.pal    = tile_pal;
        t.prio   = tile_prio;
        t.col    = tile_col;
        obs.push_back(t);
      end
    end
  end

  task automatic build_exp(input int ln, input int vs, input logic [3:0] nb);
    int row, fine, trow, a, idx, fr;
    logic [7:0] lo, hi, b;
    tile_t t;
    exp_q.delete();
    row  = (ln + vs) % 224;
    fine = row % 8;
    trow = row / 8;
    for (int col = 0; col < 32; col++) begin
      a   = int'(nb[3:1]) * 2048 + trow * 64 + col * 2;
      lo  = vram[14'(a)];
      hi  = vram[14'(a + 1)];
      idx = int'(hi[0]) * 256 + int'(lo);
      fr  = hi[2] ? 7 - fine : fine;
      for (int p = 0; p < 4; p++) begin
        b = vram[14'(idx * 32 + fr * 4 + p)];
        for (int j = 0; j < 8; j++)
          t.planes[2'(p)][3'(j)] = hi[1] ? b[3'(7 - j)] : b[3'(j)];
      end
      t.pal  = hi[3];
      t.prio = hi[4];
      t.col  = 5'(col);
      exp_q.push_back(t);
    end
  endtask

  function automatic int stream_errs(input int base);
    int e = 0;
    for (int i = 0; i < 32; i++)
      if (base + i >= obs.size() || obs[base + i] !== exp_q[i]) e++;
    return e;
  endfunction

  task automatic start_line(input int ln, input int vs, input logic [3:0] nb);
    @(posedge clk_100); #1;
    line       = 8'(ln);
    v_scroll   = 8'(vs);
    nt_base    = nb;
    line_start = 1'b1;
    @(posedge clk_100); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_line(input int budget, output bit ok);
    int d0 = done_cnt;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk_100); #1;
      tile_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom & 1);
      @(negedge clk_100); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    total++;
    if ({vga_addr, VRAM_go, tile_valid, tile_planes, tile_pal, tile_prio, tile_col, busy, line_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: go=%0b valid=%0b col=%0d busy=%0b done=%0b addr0=%h required all 0",
               VRAM_go, tile_valid, tile_col, busy, line_done, vga_addr[0]);
    end
    @(posedge clk_100); #1;
    rst_L = 1'b1;
    repeat (20) @(posedge clk_100);
    @(negedge clk_100); #1;
    total++;
    if (go_cnt !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_go: go_cnt=%0d busy=%0b required 0 0", go_cnt, busy);
    end
  endtask

  task automatic test_first_burst();
    int ob, gb, db, e;
    bit ok;
    for (int i = 0; i < 64; i++) vram[14'(14'h3800 + i)] = 8'h00;
    ob = obs.size(); gb = go_cnt; db = done_cnt;
    rdy_mode = 0;
    build_exp(0, 0, 4'hE);
    start_line(0, 0, 4'hE);
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL first_timeout: ok=%0b required 1", ok); end
    total++;
    if (go_addr[gb][0] !== 14'h3800 || go_addr[gb][1] !== 14'h3801 || go_addr[gb][7] !== 14'h3807) begin
      bad++;
      $display("FAIL first_nt_addr: got %h %h %h required 3800 3801 3807",
               go_addr[gb][0], go_addr[gb][1], go_addr[gb][7]);
    end
    total++;
    if (go_cnt - gb !== 24 || obs.size() - ob !== 32 || done_cnt - db !== 1) begin
      bad++;
      $display("FAIL first_counts: go=%0d tiles=%0d done=%0d required 24 32 1",
               go_cnt - gb, obs.size() - ob, done_cnt - db);
    end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL first_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_wrap();
    int ob, gb, e;
    bit ok;
    logic [7:0] lo0, lo1;
    lo0 = 8'($urandom); lo1 = 8'($urandom);
    vram[14'h3800] = lo0; vram[14'h3801] = 8'h00;
    vram[14'h3802] = lo1; vram[14'h3803] = 8'h00;
    ob = obs.size(); gb = go_cnt;
    rdy_mode = 1;
    build_exp(191, 40, 4'hE);
    start_line(191, 40, 4'hE);
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL wrap_timeout: ok=%0b required 1", ok); end
    total++;
    if (go_addr[gb][0] !== 14'h3800) begin
      bad++; $display("FAIL wrap_nt_trow: got %h required 3800", go_addr[gb][0]);
    end
    total++;
    if (go_addr[gb + 1][0] !== {1'b0, lo0, 3'd7, 2'd0} || go_addr[gb + 1][5] !== {1'b0, lo1, 3'd7, 2'd1}) begin
      bad++;
      $display("FAIL wrap_fine7: got %h %h required %h %h", go_addr[gb + 1][0], go_addr[gb + 1][5],
               {1'b0, lo0, 3'd7, 2'd0}, {1'b0, lo1, 3'd7, 2'd1});
    end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL wrap_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_flip();
    int ob, gb, e;
    bit ok;
    logic [3:0][7:0] pv;
    logic [13:0] a;
    vram[14'h3800] = 8'h05; vram[14'h3801] = 8'h02;
    vram[14'h3802] = 8'h05; vram[14'h3803] = 8'h04;
    for (int p = 0; p < 4; p++) begin
      a = {9'h005, 3'd0, 2'(p)};
      vram[a] = 8'h80;
      pv[2'(p)] = 8'($urandom);
      a = {9'h005, 3'd7, 2'(p)};
      vram[a] = pv[2'(p)];
    end
    ob = obs.size(); gb = go_cnt;
    rdy_mode = 0;
    build_exp(0, 0, 4'hE);
    start_line(0, 0, 4'hE);
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL flip_timeout: ok=%0b required 1", ok); end
    total++;
    if (obs[ob].planes !== {4{8'h01}}) begin
      bad++; $display("FAIL hflip_planes: got %h required 01010101", obs[ob].planes);
    end
    total++;
    if (go_addr[gb + 1][4] !== {9'h005, 3'd7, 2'd0} || go_addr[gb + 1][7] !== {9'h005, 3'd7, 2'd3}) begin
      bad++;
      $display("FAIL vflip_addr: got %h %h required %h %h", go_addr[gb + 1][4], go_addr[gb + 1][7],
               {9'h005, 3'd7, 2'd0}, {9'h005, 3'd7, 2'd3});
    end
    total++;
    if (obs[ob + 1].planes !== pv) begin
      bad++; $display("FAIL vflip_planes: got %h required %h", obs[ob + 1].planes, pv);
    end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL flip_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_stall();
    int ob, g0, e;
    bit ok;
    ob = obs.size();
    tile_ready = 1'b0;
    build_exp(100, 17, 4'h6);
    start_line(100, 17, 4'h6);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk_100); #1;
      if (tile_valid) begin ok = 1'b1; break; end
    end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL stall_reach_emit: valid=%0b required 1", tile_valid); end
    g0 = go_cnt;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk_100); #1;
      total++;
      if (tile_valid !== 1'b1 || tile_col !== 5'd0 || tile_planes !== exp_q[0].planes) begin
        bad++;
        $display("FAIL stall_hold cycle %0d: valid=%0b col=%0d planes=%h required 1 0 %h",
                 n, tile_valid, tile_col, tile_planes, exp_q[0].planes);
      end
    end
    total++;
    if (go_cnt !== g0) begin bad++; $display("FAIL stall_no_go: go pulses=%0d required 0", go_cnt - g0); end
    rdy_mode = 1;
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL stall_timeout: ok=%0b required 1", ok); end
    e = stream_errs(ob);
    total++;
    if (e !== 0 || obs.size() - ob !== 32) begin
      bad++; $display("FAIL stall_stream: mismatched=%0d tiles=%0d required 0 32", e, obs.size() - ob);
    end
  endtask

  task automatic test_busy_ignore();
    int ob, gb, db, e;
    bit ok;
    ob = obs.size(); gb = go_cnt; db = done_cnt;
    rdy_mode = 1;
    build_exp(57, 200, 4'h3);
    start_line(57, 200, 4'h3);
    repeat (30) @(posedge clk_100);
    #1;
    line = 8'd5; v_scroll = 8'd9; line_start = 1'b1;
    @(posedge clk_100); #1;
    line_start = 1'b0;
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL ignore_timeout: ok=%0b required 1", ok); end
    repeat (20) @(posedge clk_100);
    @(negedge clk_100); #1;
    total++;
    if (go_cnt - gb !== 24 || obs.size() - ob !== 32 || done_cnt - db !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL ignore_counts: go=%0d tiles=%0d done=%0d busy=%0b required 24 32 1 0",
               go_cnt - gb, obs.size() - ob, done_cnt - db, busy);
    end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL ignore_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_reset_mid();
    int ob, gb, e;
    bit ok;
    gb = go_cnt;
    tile_ready = 1'b1;
    start_line(120, 3, 4'hA);
    ok = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk_100); #1;
      if (go_cnt - gb == 11) begin ok = 1'b1; break; end
    end
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL rmid_reach: go pulses=%0d required 11", go_cnt - gb); end
    @(posedge clk_100);
    @(posedge clk_100);
    #3 rst_L = 1'b0;
    #1;
    total++;
    if ({vga_addr, VRAM_go, tile_valid, tile_planes, tile_pal, tile_prio, tile_col, busy, line_done} !== '0) begin
      bad++;
      $display("FAIL rmid_outputs: go=%0b valid=%0b col=%0d busy=%0b addr0=%h required all 0",
               VRAM_go, tile_valid, tile_col, busy, vga_addr[0]);
    end
    @(posedge clk_100); #1;
    rst_L = 1'b1;
    ob = obs.size();
    rdy_mode = 1;
    build_exp(33, 77, 4'h5);
    start_line(33, 77, 4'h5);
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL rmid_timeout: ok=%0b required 1", ok); end
    total++;
    if (obs.size() - ob !== 32 || obs[ob].col !== 5'd0) begin
      bad++; $display("FAIL rmid_restart: tiles=%0d first col=%0d required 32 0", obs.size() - ob, obs[ob].col);
    end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL rmid_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_back_to_back();
    int ob, e;
    bit ok;
    ob = obs.size();
    rdy_mode = 0;
    build_exp(10, 250, 4'hC);
    start_line(10, 250, 4'hC);
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL b2b_first_timeout: ok=%0b required 1", ok); end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL b2b_first_stream: mismatched tiles=%0d required 0", e); end
    ob = obs.size();
    build_exp(180, 44, 4'h2);
    start_line(180, 44, 4'h2);
    total++;
    if (busy !== 1'b1 || VRAM_go !== 1'b1) begin
      bad++; $display("FAIL b2b_accept: busy=%0b go=%0b required 1 1", busy, VRAM_go);
    end
    wait_line(3000, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL b2b_second_timeout: ok=%0b required 1", ok); end
    e = stream_errs(ob);
    total++;
    if (e !== 0) begin bad++; $display("FAIL b2b_second_stream: mismatched tiles=%0d required 0", e); end
  endtask

  task automatic test_random();
    int ob, gb, e, ln, vs;
    logic [3:0] nb;
    bit ok;
    for (int r = 0; r < 6; r++) begin
      ln = (r == 0) ? 191 : int'($urandom_range(0, 191));
      vs = (r == 0) ? 255 : int'($urandom_range(0, 255));
      nb = 4'($urandom);
      rdy_mode = r % 2;
      ob = obs.size(); gb = go_cnt;
      build_exp(ln, vs, nb);
      start_line(ln, vs, nb);
      wait_line(3000, ok);
      e = stream_errs(ob);
      total++;
      if (ok !== 1'b1 || e !== 0 || go_cnt - gb !== 24) begin
        bad++;
        $display("FAIL random_line %0d (line=%0d vs=%0d nt=%h): done=%0b mismatched=%0d go=%0d required 1 0 24",
                 r, ln, vs, nb, ok, e, go_cnt - gb);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'($urandom);
    test_reset();
    test_first_burst();
    test_wrap();
    test_flip();
    test_stall();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
